// File: rtl/count_mon_pkg.sv
// Shared types for the counter invariant monitor: FSM states, violation codes
// and the first-error priority helper.
package count_mon_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    INIT_CHK = 2'd1,
    TRACK    = 2'd2,
    DONE     = 2'd3
  } mon_state_e;

  localparam logic [2:0] CODE_NONE  = 3'd0;
  localparam logic [2:0] CODE_INIT  = 3'd1;
  localparam logic [2:0] CODE_SUM   = 3'd2;
  localparam logic [2:0] CODE_STEP  = 3'd3;
  localparam logic [2:0] CODE_BOUND = 3'd4;
  localparam logic [2:0] CODE_WDOG  = 3'd5;

  // Bit k of hits flags violation code k; the lowest set code is reported.
  function automatic logic [2:0] pick_code(input logic [5:1] hits);
    logic [2:0] code;
    code = CODE_NONE;
    for (int k = 5; k >= 1; k--) begin
      if (hits[k]) begin
        code = 3'(k);
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/count_ref_model.sv
// Cycle-accurate shadow of the bounded selector-gated counter, re-seeded each
// cycle from the observed outputs so every step is judged on its own.
module count_ref_model #(
  parameter int W     = 10,
  parameter int LIMIT = 300
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sel_i,
  input  logic [W-1:0] sn_i,
  input  logic [W-1:0] i_i,
  output logic         exp_adv_o,
  output logic [W:0]   exp_sn_o,
  output logic [W:0]   exp_i_o
);

  localparam logic [W:0] LIMIT_X = (W+1)'(LIMIT);

  logic         prev_sel_q;
  logic [W-1:0] prev_i_q;
  logic [W-1:0] prev_sn_q;

  // Previous-cycle selector and counter values; reset mirrors the counter's reset state.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_sel_q <= 1'b0;
      prev_i_q   <= W'(1);
      prev_sn_q  <= '0;
    end else begin
      prev_sel_q <= sel_i;
      prev_i_q   <= i_i;
      prev_sn_q  <= sn_i;
    end
  end

  // Expected values are one bit wider so a wrap at 2^W shows up as a mismatch.
  assign exp_adv_o = prev_sel_q && ({1'b0, prev_i_q} <= LIMIT_X);
  assign exp_i_o   = {1'b0, prev_i_q}  + {{W{1'b0}}, exp_adv_o};
  assign exp_sn_o  = {1'b0, prev_sn_q} + {{W{1'b0}}, exp_adv_o};

endmodule

// File: rtl/count_invariant_monitor.sv
// Checker for the bounded sn/i counter: step, sum and bound invariants, sticky
// first-error snapshot. Optional idle watchdog under COUNT_MON_WDOG_EN.
module count_invariant_monitor
  import count_mon_pkg::*;
#(
  parameter int W        = 10,
  parameter int LIMIT    = 300,
  parameter int VCNT_W   = 8,
  parameter int WDOG_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel_in,
  input  logic [W-1:0]      sn_in,
  input  logic [W-1:0]      i_in,
  output logic              done,
  output logic              err,
  output logic [2:0]        err_code,
  output logic [W-1:0]      err_sn,
  output logic [W-1:0]      err_i,
  output logic [VCNT_W-1:0] viol_cnt,
  output logic [W-1:0]      adv_cnt
);

  localparam logic [W:0] LIMIT_P1 = (W+1)'(LIMIT + 1);

  mon_state_e        state_q, state_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [2:0]        code_q, code_d;
  logic [W-1:0]      esn_q, esn_d;
  logic [W-1:0]      ei_q, ei_d;
  logic [VCNT_W-1:0] viol_q, viol_d;
  logic [W-1:0]      adv_q, adv_d;

  logic              exp_adv_s;
  logic [W:0]        exp_sn_s, exp_i_s;
  logic              init_bad_s, sum_bad_s, bound_bad_s, step_bad_s, wdog_hit_s;
  logic [5:1]        hits_s;

  count_ref_model #(.W(W), .LIMIT(LIMIT)) u_ref (
    .clk       (clk),
    .rst       (rst),
    .sel_i     (sel_in),
    .sn_i      (sn_in),
    .i_i       (i_in),
    .exp_adv_o (exp_adv_s),
    .exp_sn_o  (exp_sn_s),
    .exp_i_o   (exp_i_s)
  );

  assign init_bad_s  = (sn_in != '0) || (i_in != W'(1));
  assign sum_bad_s   = (({1'b0, sn_in} + (W+1)'(1)) != {1'b0, i_in});
  assign bound_bad_s = ({1'b0, i_in} > LIMIT_P1);
  assign step_bad_s  = ({1'b0, sn_in} != exp_sn_s) || ({1'b0, i_in} != exp_i_s);

`ifdef COUNT_MON_WDOG_EN
  localparam int IDLE_W = $clog2(WDOG_CYC + 1);
  logic [IDLE_W-1:0] idle_q, idle_d;

  // Idle counter: TRACK cycles without a matched advance; fires once per WDOG_CYC then re-arms.
  always_comb begin
    idle_d     = '0;
    wdog_hit_s = 1'b0;
    if (state_q == TRACK && !(exp_adv_s && !step_bad_s)) begin
      if (idle_q == IDLE_W'(WDOG_CYC - 1)) begin
        wdog_hit_s = 1'b1;
      end else begin
        idle_d = idle_q + IDLE_W'(1);
      end
    end
  end

  // Idle counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  assign wdog_hit_s = 1'b0;
`endif

  // Next state, violation flags and snapshot/counter updates.
  always_comb begin
    state_d = state_q;
    hits_s  = '0;
    adv_d   = adv_q;
    case (state_q)
      // IDLE only spans reset; the first sampled cycle after it is the initial-value check.
      IDLE, INIT_CHK: begin
        hits_s[1] = init_bad_s;
        hits_s[2] = sum_bad_s;
        hits_s[4] = bound_bad_s;
        state_d   = TRACK;
      end
      TRACK: begin
        hits_s[2] = sum_bad_s;
        hits_s[3] = step_bad_s;
        hits_s[4] = bound_bad_s;
        hits_s[5] = wdog_hit_s;
        if (exp_adv_s && !step_bad_s) begin
          adv_d = adv_q + W'(1);
        end
        if (({1'b0, i_in} == LIMIT_P1) && !err_q && (hits_s == '0)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        hits_s[2] = sum_bad_s;
        hits_s[3] = step_bad_s;
        hits_s[4] = bound_bad_s;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    err_d  = err_q | (|hits_s);
    code_d = code_q;
    esn_d  = esn_q;
    ei_d   = ei_q;
    if (!err_q && (|hits_s)) begin
      code_d = pick_code(hits_s);
      esn_d  = sn_in;
      ei_d   = i_in;
    end

    viol_d = viol_q;
    if ((|hits_s) && (viol_q != '1)) begin
      viol_d = viol_q + VCNT_W'(1);
    end

    done_d = (state_d == DONE) && !err_d;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= CODE_NONE;
      esn_q   <= '0;
      ei_q    <= '0;
      viol_q  <= '0;
      adv_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
      esn_q   <= esn_d;
      ei_q    <= ei_d;
      viol_q  <= viol_d;
      adv_q   <= adv_d;
    end
  end

  assign done     = done_q;
  assign err      = err_q;
  assign err_code = code_q;
  assign err_sn   = esn_q;
  assign err_i    = ei_q;
  assign viol_cnt = viol_q;
  assign adv_cnt  = adv_q;

endmodule
